// File: rtl/prod_acc_pkg.sv
// Shared types and default sizing for the product accumulator.
package prod_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int DEF_ACC_W     = 12;
    localparam int DEF_MAX_TERMS = 16;

endpackage

// File: rtl/prod_acc_ctrl.sv
// Burst control for the product accumulator: IDLE/ACC/HOLD FSM, beat counter and the forced-close flag.
module prod_acc_ctrl
    import prod_acc_pkg::*;
#(
    parameter int MAX_TERMS = DEF_MAX_TERMS,
    parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    input  logic             in_last_i,
    input  logic             out_ready_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic             load_o,
    output logic             add_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             forced_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             forced_q, forced_d;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;

    assign in_ready_o  = (state_q != HOLD);
    assign out_valid_o = (state_q == HOLD);
    assign accept      = in_valid_i & in_ready_o;
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign cnt_o       = cnt_q;
    assign forced_o    = forced_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            forced_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            forced_q <= forced_d;
        end
    end

    // in_last wins over the term limit, so a coinciding close is never marked forced.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        forced_d = forced_q;
        load_o   = 1'b0;
        add_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    load_o   = 1'b1;
                    cnt_d    = CNT_W'(1);
                    forced_d = 1'b0;
                    if (in_last_i) begin
                        state_d = HOLD;
                    end else if (MAX_TERMS == 1) begin
                        state_d  = HOLD;
                        forced_d = 1'b1;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (accept) begin
                    add_o = 1'b1;
                    cnt_d = cnt_inc;
                    if (in_last_i) begin
                        state_d  = HOLD;
                        forced_d = 1'b0;
                    end else if (cnt_inc == CNT_W'(MAX_TERMS)) begin
                        state_d  = HOLD;
                        forced_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready_i) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    forced_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/prod_accumulator.sv
// Sums a burst of unsigned 4x4 products and holds the result until the consumer takes it.
// Define PROD_ACC_SAT_EN to clamp on overflow instead of wrapping modulo 2^ACC_W.
module prod_accumulator
    import prod_acc_pkg::*;
#(
    parameter int ACC_W     = DEF_ACC_W,
    parameter int MAX_TERMS = DEF_MAX_TERMS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [7:0]                     R,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACC_W-1:0]               acc_out,
    output logic [$clog2(MAX_TERMS+1)-1:0] cnt_out,
    output logic                           ovf,
    output logic                           forced
);

    localparam int CNT_W = $clog2(MAX_TERMS + 1);

    logic             load, add;
    logic [CNT_W-1:0] cnt;
    logic             forced_int;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum;

    function automatic logic [ACC_W-1:0] fit_sum(input logic [ACC_W:0] s);
`ifdef PROD_ACC_SAT_EN
        fit_sum = s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
        fit_sum = s[ACC_W-1:0];
`endif
    endfunction

    prod_acc_ctrl #(
        .MAX_TERMS (MAX_TERMS),
        .CNT_W     (CNT_W)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_last_i   (in_last),
        .out_ready_i (out_ready),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .load_o      (load),
        .add_o       (add),
        .cnt_o       (cnt),
        .forced_o    (forced_int)
    );

    assign sum = {1'b0, acc_q} + (ACC_W+1)'(R);

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (load) begin
            acc_d = ACC_W'(R);
            ovf_d = 1'b0;
        end else if (add) begin
            acc_d = fit_sum(sum);
            ovf_d = ovf_q | sum[ACC_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    // Result fields read as zero whenever nothing is held.
    assign acc_out = out_valid ? acc_q : '0;
    assign cnt_out = out_valid ? cnt : '0;
    assign ovf     = out_valid & ovf_q;
    assign forced  = out_valid & forced_int;

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed bench for prod_accumulator: a default-size instance plus an ACC_W=8 instance for overflow.
module tb_prod_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_last, out_ready;
    logic [7:0]  R;
    logic        in_ready, out_valid, ovf, forced;
    logic [11:0] acc_out;
    logic [4:0]  cnt_out;

    logic        v8, l8, ordy8;
    logic [7:0]  r8;
    logic        rdy8, ov8, ovf8, frc8;
    logic [7:0]  acc8;
    logic [4:0]  cnt8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    prod_accumulator dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .R(R),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .cnt_out(cnt_out), .ovf(ovf), .forced(forced)
    );

    prod_accumulator #(.ACC_W(8), .MAX_TERMS(16)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .R(r8),
        .in_last(l8), .out_valid(ov8), .out_ready(ordy8),
        .acc_out(acc8), .cnt_out(cnt8), .ovf(ovf8), .forced(frc8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] r, input logic last);
        in_valid = 1'b1; R = r; in_last = last;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send8(input logic [7:0] r, input logic last);
        v8 = 1'b1; r8 = r; l8 = last;
        @(negedge clk);
        v8 = 1'b0; l8 = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_acc", acc_out, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_last = 0; out_ready = 0; R = 0;
        v8 = 0; l8 = 0; ordy8 = 0; r8 = 0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_acc", acc_out, 0);
        check("rst_cnt", cnt_out, 0);
        check("rst_ovf", ovf, 0);
        check("rst_forced", forced, 0);
        @(negedge clk);
        check("rst_ready", in_ready, 1);

        // Single beat 0x31 with in_last
        send(8'h31, 1'b1);
        check("one_valid", out_valid, 1);
        check("one_acc", acc_out, 49);
        check("one_cnt", cnt_out, 1);
        check("one_forced", forced, 0);
        check("one_ready", in_ready, 0);
        release_result();

        // 15, 30, gap, 225, 0(last)
        send(8'd15, 1'b0);
        send(8'd30, 1'b0);
        check("gap_valid", out_valid, 0);
        @(negedge clk);
        check("gap_acc_hidden", acc_out, 0);
        send(8'd225, 1'b0);
        send(8'd0, 1'b1);
        check("four_valid", out_valid, 1);
        check("four_acc", acc_out, 270);
        check("four_cnt", cnt_out, 4);
        check("four_forced", forced, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_acc", acc_out, 270);
            check("stall_cnt", cnt_out, 4);
        end
        release_result();

        // 16 x 225 without in_last -> forced close
        for (int i = 0; i < 16; i++) send(8'd225, 1'b0);
        check("full_valid", out_valid, 1);
        check("full_acc", acc_out, 3600);
        check("full_cnt", cnt_out, 16);
        check("full_forced", forced, 1);
        check("full_ovf", ovf, 0);
        check("full_ready", in_ready, 0);
        send(8'd7, 1'b1);
        check("hold_ignore_acc", acc_out, 3600);
        check("hold_ignore_cnt", cnt_out, 16);
        release_result();
        check("after_ready", in_ready, 1);

        // in_last coinciding with the 16th beat is not forced
        for (int i = 0; i < 15; i++) send(8'd1, 1'b0);
        send(8'd1, 1'b1);
        check("coin_acc", acc_out, 16);
        check("coin_cnt", cnt_out, 16);
        check("coin_forced", forced, 0);
        release_result();

        // Reset mid-burst discards the partial sum
        send(8'd10, 1'b0);
        send(8'd20, 1'b0);
        send(8'd30, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rstacc_valid", out_valid, 0);
            @(negedge clk);
        end
        send(8'd5, 1'b1);
        check("fresh_acc", acc_out, 5);
        check("fresh_cnt", cnt_out, 1);
        release_result();

        // Reset beats a closing beat in the same cycle
        rst = 1'b1;
        send(8'd7, 1'b1);
        rst = 1'b0;
        check("rstprio_valid", out_valid, 0);
        @(negedge clk);
        check("rstprio_valid2", out_valid, 0);

        // 8-bit accumulator: 200 + 100
        send8(8'd200, 1'b0);
        send8(8'd100, 1'b1);
        check("ovf_valid", ov8, 1);
`ifdef PROD_ACC_SAT_EN
        check("ovf_acc", acc8, 255);
`else
        check("ovf_acc", acc8, 44);
`endif
        check("ovf_flag", ovf8, 1);
        check("ovf_cnt", cnt8, 2);
        ordy8 = 1'b1;
        @(negedge clk);
        ordy8 = 1'b0;
        check("ovf_release", ov8, 0);
        send8(8'd3, 1'b1);
        check("ovf_cleared", ovf8, 0);
        check("ovf_next_acc", acc8, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
